// File: rtl/floppy_voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events onto floppy drive channels,
// reusing a matching or free channel first and stealing round-robin otherwise.
module floppy_voice_alloc #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned SP_W   = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic                   ev_on,
  input  logic [6:0]             ev_note,
  input  logic [SP_W-1:0]        ev_setpoint,
  input  logic                   all_off,
  output logic [NUM_CH-1:0]      ch_enable,
  output logic [NUM_CH*SP_W-1:0] ch_setpoint,
  output logic [IDX_W:0]         active_count,
  output logic                   steal_pulse
);

  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned NOTE_W = 7;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

  state_t              state;
  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    steal_ptr;
  logic                lat_on;
  logic [NOTE_W-1:0]   lat_note;
  logic [SP_W-1:0]     lat_sp;
  logic                match_found;
  logic [IDX_W-1:0]    match_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic [NOTE_W-1:0]   note_tab [NUM_CH];
  logic [SP_W-1:0]     sp_tab   [NUM_CH];

  logic [NUM_CH-1:0]   en_nxt;
  logic                wr_sp;
  logic                wr_note;
  logic [IDX_W-1:0]    wr_idx;
  logic                steal;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign ev_ready = rst_n & (state == IDLE) & ~all_off;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sp
    assign ch_setpoint[g*SP_W +: SP_W] = sp_tab[g];
  end

  // Resolve the scanned event: retrigger, then free channel, then steal.
  always_comb begin
    en_nxt  = ch_enable;
    wr_sp   = 1'b0;
    wr_note = 1'b0;
    wr_idx  = '0;
    steal   = 1'b0;
    if (state == APPLY) begin
      if (lat_on && (lat_sp != '0)) begin
        wr_sp = 1'b1;
        if (match_found) begin
          wr_idx = match_idx;
        end else if (free_found) begin
          wr_note         = 1'b1;
          wr_idx          = free_idx;
          en_nxt[free_idx] = 1'b1;
        end else begin
          wr_note = 1'b1;
          wr_idx  = steal_ptr;
          steal   = 1'b1;
        end
      end else if (match_found) begin
        en_nxt[match_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      scan_idx     <= '0;
      steal_ptr    <= '0;
      lat_on       <= 1'b0;
      lat_note     <= '0;
      lat_sp       <= '0;
      match_found  <= 1'b0;
      match_idx    <= '0;
      free_found   <= 1'b0;
      free_idx     <= '0;
      ch_enable    <= '0;
      active_count <= '0;
      steal_pulse  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        note_tab[i] <= '0;
        sp_tab[i]   <= '0;
      end
    end else if (all_off) begin
      ch_enable    <= '0;
      active_count <= '0;
      steal_pulse  <= 1'b0;
      state        <= IDLE;
    end else begin
      steal_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_valid && ev_ready) begin
            lat_on      <= ev_on;
            lat_note    <= ev_note;
            lat_sp      <= ev_setpoint;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            scan_idx    <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (!match_found && ch_enable[scan_idx] && (note_tab[scan_idx] == lat_note)) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!free_found && !ch_enable[scan_idx]) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (scan_idx == IDX_W'(NUM_CH - 1)) state <= APPLY;
          else scan_idx <= scan_idx + IDX_W'(1);
        end
        APPLY: begin
          ch_enable    <= en_nxt;
          active_count <= popcount(en_nxt);
          if (wr_sp)   sp_tab[wr_idx]   <= lat_sp;
          if (wr_note) note_tab[wr_idx] <= lat_note;
          if (steal) begin
            steal_pulse <= 1'b1;
            steal_ptr   <= (steal_ptr == IDX_W'(NUM_CH - 1)) ? '0 : steal_ptr + IDX_W'(1);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floppy_voice_alloc.sv
// Randomized scoreboard bench for floppy_voice_alloc against a channel-table model.
module tb_floppy_voice_alloc;

  localparam int NCH = 4;
  localparam int IW  = 2;
  localparam int SPW = 22;
  localparam int LAT = NCH + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ev_valid = 1'b0;
  logic ev_ready;
  logic ev_on = 1'b0;
  logic [6:0] ev_note = '0;
  logic [SPW-1:0] ev_setpoint = '0;
  logic all_off = 1'b0;
  logic [NCH-1:0] ch_enable;
  logic [NCH*SPW-1:0] ch_setpoint;
  logic [IW:0] active_count;
  logic steal_pulse;

  floppy_voice_alloc #(.NUM_CH(NCH), .IDX_W(IW), .SP_W(SPW)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_setpoint(ev_setpoint), .all_off(all_off),
    .ch_enable(ch_enable), .ch_setpoint(ch_setpoint), .active_count(active_count),
    .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int               due;
    logic [NCH-1:0]   en;
    logic [NCH*SPW-1:0] sp;
    logic [IW:0]      cnt;
    logic             steal;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference channel table.
  bit       m_en [NCH];
  int       m_note [NCH];
  int       m_sp [NCH];
  int       m_ptr;
  bit       p_en [NCH];
  int       p_note [NCH];
  int       p_sp [NCH];
  int       p_ptr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t snap(input int due, input bit stl);
    exp_t e;
    int c = 0;
    e.due = due;
    e.steal = stl;
    for (int i = 0; i < NCH; i++) begin
      e.en[i] = m_en[i];
      e.sp[i*SPW +: SPW] = SPW'(m_sp[i]);
      c += int'(m_en[i]);
    end
    e.cnt = (IW+1)'(c);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_note[i] = 0; m_sp[i] = 0;
    end
    m_ptr = 0;
  endtask

  // Returns whether the event stole a channel.
  function automatic bit model_event(input bit on, input int note, input int sp);
    int m = -1;
    int f = -1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m_en[i] && m_note[i] == note) m = i;
      if (!m_en[i]) f = i;
    end
    if (on && sp != 0) begin
      if (m >= 0) m_sp[m] = sp;
      else if (f >= 0) begin m_en[f] = 1; m_note[f] = note; m_sp[f] = sp; end
      else begin
        m_note[m_ptr] = note; m_sp[m_ptr] = sp;
        m_ptr = (m_ptr + 1) % NCH;
        return 1;
      end
    end else if (m >= 0) begin
      m_en[m] = 0;
    end
    return 0;
  endfunction

  // Issue one event from a negedge; returns at the negedge where the DUT is idle again.
  // abort: 0 none, 1 all_off on the apply edge, 2 reset mid-scan.
  task automatic send(input bit on, input int note, input int sp, input int abort);
    int k;
    bit stl;
    bit ok = 0;
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(note); ev_setpoint = SPW'(sp);
    #1;
    for (int t = 0; t < 20; t++) begin
      if (ev_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    if (!ok) begin
      chk("ready_timeout", 128'(ev_ready), 128'(1));
      ev_valid = 1'b0;
      return;
    end
    k = cyc + 1;
    for (int i = 0; i < NCH; i++) begin p_en[i] = m_en[i]; p_note[i] = m_note[i]; p_sp[i] = m_sp[i]; end
    p_ptr = m_ptr;
    stl = model_event(on, note, sp);
    q.push_back(snap(k + LAT, stl));
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0; ev_on = $urandom_range(1, 0) == 1; ev_note = 7'($urandom); ev_setpoint = SPW'($urandom);
    chk("busy_ready", 128'(ev_ready), 128'(0));
    if (abort == 2) begin
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      void'(q.pop_back());
      model_reset();
      q.push_back(snap(k + 3, 0));
      #1 chk("ready_in_reset", 128'(ev_ready), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("ready_after_reset", 128'(ev_ready), 128'(1));
      return;
    end
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      if (abort == 1 && i == LAT - 1) begin
        all_off = 1'b1;
        void'(q.pop_back());
        for (int j = 0; j < NCH; j++) begin m_en[j] = 0; m_note[j] = p_note[j]; m_sp[j] = p_sp[j]; end
        m_ptr = p_ptr;
        q.push_back(snap(k + LAT, 0));
      end else begin
        chk("busy_ready", 128'(ev_ready), 128'(0));
      end
    end
    @(negedge clk);
    all_off = 1'b0;
    #1 chk("ready_again", 128'(ev_ready), 128'(1));
  endtask

  task automatic idle_all_off();
    all_off = 1'b1;
    #1 chk("ready_all_off", 128'(ev_ready), 128'(0));
    for (int i = 0; i < NCH; i++) m_en[i] = 0;
    q.push_back(snap(cyc + 1, 0));
    @(negedge clk);
    all_off = 1'b0;
  endtask

  // Monitor: compare registered outputs against the queued expectation when due.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("ch_enable", 128'(ch_enable), 128'(q[0].en));
      chk("ch_setpoint", 128'(ch_setpoint), 128'(q[0].sp));
      chk("active_count", 128'(active_count), 128'(q[0].cnt));
      chk("steal_pulse", 128'(steal_pulse), 128'(q[0].steal));
      void'(q.pop_front());
    end else if (cyc > 0) begin
      chk("steal_idle", 128'(steal_pulse), 128'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 128'(ev_ready), 128'(0));
    chk("reset_enable", 128'(ch_enable), 128'(0));
    chk("reset_setpoint", 128'(ch_setpoint), 128'(0));
    chk("reset_count", 128'(active_count), 128'(0));
    rst_n = 1'b1;

    send(1, 60, 1000, 0);
    send(0, 61, 0, 0);
    send(1, 60, 1200, 0);
    send(1, 62, 900, 0);
    send(1, 64, 800, 0);
    send(1, 65, 700, 0);
    send(1, 67, 600, 0);
    send(1, 69, 550, 0);
    send(0, 64, 0, 0);
    send(1, 70, 500, 0);
    send(1, 64, 0, 0);
    send(1, 70, 0, 0);
    send(1, 71, 400, 1);
    send(1, 72, 300, 0);
    send(1, 73, 200, 2);
    send(1, 60, 1000, 0);

    for (int n = 0; n < 300; n++) begin
      int r = int'($urandom_range(99, 0));
      int ab = (r < 3) ? 1 : (r < 5) ? 2 : 0;
      int sp = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(4194303, 1));
      if (r >= 95) idle_all_off();
      send($urandom_range(2, 0) != 0, int'($urandom_range(67, 60)), sp, ab);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/floppy_voice_alloc.md
Name: floppy_voice_alloc

Overview:
- Polyphonic voice allocator for a bank of floppy step generators.
- Accepts note-on/note-off events over a valid/ready handshake.
- Assigns each note to a free drive channel, or steals one round-robin when none is free. Drives per-channel enable and half-period setpoint buses straight into the drive instances.
- Sits between the MIDI parser/note-to-period lookup and the array of floppy step generators.

Parameters:
- NUM_CH, 8, number of drive channels (2..16).
- IDX_W, 3, channel index width; 2**IDX_W >= NUM_CH.
- SP_W, 22, setpoint width (half-period in clk cycles).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note number.
- ev_setpoint  in  SP_W  half-period for note-on; ignored for note-off.
- all_off  in  1  panic: silence every channel.
- ch_enable  out  NUM_CH  per-channel drive enable.
- ch_setpoint  out  NUM_CH*SP_W  flat bus; channel i at [i*SP_W +: SP_W].
- active_count  out  IDX_W+1  number of set ch_enable bits.
- steal_pulse  out  1  one-cycle strobe when a channel is stolen.

Behaviour:
- All outputs and state are registered. On any edge with rst_n=0:
  - ch_enable=0, ch_setpoint=0, active_count=0, steal_pulse=0.
  - Internal note table = 0, steal_ptr=0, state=IDLE.
- ev_ready = (state==IDLE) & ~all_off. It is 0 while rst_n=0.
- FSM IDLE: on an edge with ev_valid & ev_ready, latch ev_on/ev_note/ev_setpoint, clear the scan flags, set scan index=0, and go to SCAN.
- FSM SCAN: examines one channel per cycle, index 0..NUM_CH-1, for exactly NUM_CH cycles, then goes to APPLY.
  - Match flag: the first (lowest) channel with enable=1 and note==latched note.
  - Free flag: the first (lowest) channel with enable=0.
- FSM APPLY: one cycle; updates outputs on this edge, then returns to IDLE.
- Latency: event accepted at edge k → outputs change at edge k+NUM_CH+1 → ev_ready high again in the following cycle. Event-to-event throughput is NUM_CH+2 cycles.
- Note-on with setpoint != 0, resolved in this priority order:
  - (a) Match: retrigger. Overwrite that channel's setpoint; enable stays 1; no new channel.
  - (b) Else free: enable the lowest free channel and load its note and setpoint.
  - (c) Else steal: overwrite the note and setpoint of channel steal_ptr (enable stays 1). Pulse steal_pulse=1 for one cycle. steal_ptr advances by 1, wrapping NUM_CH-1 → 0.
- Note-on with setpoint == 0: handled exactly as note-off (a zero setpoint would toggle the drive every clock).
- Note-off: on match, clear that channel's enable; its setpoint and note are left unchanged. With no match, nothing changes (no error).
- steal_ptr changes only on a steal; frees do not move it.
- active_count is updated on the same edge as ch_enable and always equals popcount(ch_enable).
- all_off, sampled on any edge with rst_n=1, in any state:
  - ch_enable=0, active_count=0, state=IDLE.
  - Any in-flight event is dropped.
  - ch_setpoint and steal_ptr are kept.
  - all_off has priority over an APPLY on the same edge.
- Reset mid-SCAN/APPLY: the event is discarded and reset values apply.
- ev_* inputs are ignored outside IDLE. The requester must hold ev_* stable only until the handshake completes.

Test Plan (NUM_CH=4, SP_W=22):
- Reset then note-on note 60, sp 1000 → ev_ready low for 5 cycles. At edge k+5: ch_enable=0001, ch_setpoint[0]=1000, active_count=1, steal_pulse=0.
- Note-on 60/1000, 62/900, 64/800, 65/700, then note-on 67/600 → channels 0..3 fill in order. The 5th event steals ch0: setpoint 600, enable=1111, steal_pulse one cycle. A 6th distinct note-on steals ch1.
- All four channels full, note-off 62, then note-on 70/500 → ch1 disabled then re-used; steal_pulse stays 0 and steal_ptr is unchanged.
- Note-on 60/1000, then note-on 60/1200 → same channel 0 retriggered, setpoint=1200, active_count stays 1. Note-off 61 → no change.
- Note-on 60 with setpoint 0 while 60 is active on ch2 → ch2 disabled. Same event with 60 inactive → no change.
- all_off asserted on the APPLY edge of an in-flight note-on → ch_enable=0000 and active_count=0 at that edge. The event is lost and ev_ready=1 on the next cycle (all_off low). rst_n low mid-SCAN → all outputs at reset values.
